// File: rtl/fetch_queue_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue_unit: PC owner, single-outstanding fetch FSM, branch predict |
// | and circular instruction queue. BHT predictor built only if FETCH_BHT_EN.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_queue_unit #(
  parameter int unsigned IQ_DEPTH_LOG = 2,
  parameter int unsigned BHT_LOG      = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_valid_in,
  input  logic [31:0] mem_inst_in,
  output logic        idle_to_dispatcher,
  output logic [31:0] inst_to_dispatcher,
  output logic [31:0] inst_pos_to_dispatcher,
  output logic        jump_predicted_to_dispatcher,
  output logic [31:0] rollback_pos_to_dispatcher,
  input  logic        stall_from_dispatcher,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] rollback_pos_from_rob,
  input  logic        bht_update_en_from_rob,
  input  logic [31:0] bht_update_pc_from_rob,
  input  logic        bht_taken_from_rob
);

  localparam int unsigned c_IQ_DEPTH  = 1 << IQ_DEPTH_LOG;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [31:0]           r_pc;
  logic                  r_mem_req;
  logic [31:0]           r_q_inst [c_IQ_DEPTH];
  logic [31:0]           r_q_pos  [c_IQ_DEPTH];
  logic [31:0]           r_q_alt  [c_IQ_DEPTH];
  logic                  r_q_pred [c_IQ_DEPTH];
  logic [IQ_DEPTH_LOG-1:0] r_head;
  logic [IQ_DEPTH_LOG-1:0] r_tail;
  logic [IQ_DEPTH_LOG:0]   r_count;

  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_jal;
  logic [31:0] w_pc_br;
  logic [31:0] w_next_pc;
  logic [31:0] w_alt_pc;
  logic        w_pred;
  logic        w_bht_taken;
  logic        w_idle;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  assign w_imm_j    = {{12{mem_inst_in[31]}}, mem_inst_in[19:12], mem_inst_in[20],
                       mem_inst_in[30:21], 1'b0};
  assign w_imm_b    = {{20{mem_inst_in[31]}}, mem_inst_in[7], mem_inst_in[30:25],
                       mem_inst_in[11:8], 1'b0};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_jal   = r_pc + w_imm_j;
  assign w_pc_br    = r_pc + w_imm_b;

`ifdef FETCH_BHT_EN
  localparam int c_BHT_SIZE = 1 << BHT_LOG;

  logic [1:0]         r_bht [c_BHT_SIZE];
  logic [BHT_LOG-1:0] w_bht_rd_idx;
  logic [BHT_LOG-1:0] w_bht_wr_idx;
  logic               w_unused_upd_pc_bits;

  assign w_bht_rd_idx = r_pc[BHT_LOG+1:2];
  assign w_bht_wr_idx = bht_update_pc_from_rob[BHT_LOG+1:2];
  assign w_bht_taken  = r_bht[w_bht_rd_idx][1];
  assign w_unused_upd_pc_bits = ^{bht_update_pc_from_rob[31:BHT_LOG+2],
                                  bht_update_pc_from_rob[1:0]};

  // Lookup reads the pre-edge counter, so a same-index update is seen next time.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < c_BHT_SIZE; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (rdy_in && bht_update_en_from_rob) begin
      if (bht_taken_from_rob) begin
        if (r_bht[w_bht_wr_idx] != 2'b11) begin
          r_bht[w_bht_wr_idx] <= r_bht[w_bht_wr_idx] + 2'b01;
        end
      end else if (r_bht[w_bht_wr_idx] != 2'b00) begin
        r_bht[w_bht_wr_idx] <= r_bht[w_bht_wr_idx] - 2'b01;
      end
    end
  end
`else
  logic w_unused_bht_inputs;

  assign w_bht_taken         = 1'b0;
  assign w_unused_bht_inputs = ^{bht_update_en_from_rob, bht_update_pc_from_rob,
                                 bht_taken_from_rob};
`endif

  always_comb begin
    w_pred    = 1'b0;
    w_next_pc = w_pc_plus4;
    w_alt_pc  = w_pc_plus4;
    if (mem_inst_in[6:0] == c_OP_JAL) begin
      w_pred    = 1'b1;
      w_next_pc = w_pc_jal;
    end else if (mem_inst_in[6:0] == c_OP_BRANCH) begin
      w_pred = w_bht_taken;
      if (w_bht_taken) begin
        w_next_pc = w_pc_br;
      end else begin
        w_alt_pc  = w_pc_br;
      end
    end
  end

  // Count never exceeds the depth, so its MSB alone marks a full queue.
  assign w_idle = (r_count != '0);
  assign w_full = r_count[IQ_DEPTH_LOG];
  assign w_push = rdy_in && !rollback_flag_from_rob && (r_state == S_WAIT) && mem_valid_in;
  assign w_pop  = rdy_in && !rollback_flag_from_rob && w_idle && !stall_from_dispatcher;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_q_inst[r_tail] <= mem_inst_in;
      r_q_pos[r_tail]  <= r_pc;
      r_q_alt[r_tail]  <= w_alt_pc;
      r_q_pred[r_tail] <= w_pred;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_mem_req <= 1'b0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else if (rdy_in) begin
      if (rollback_flag_from_rob) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        r_pc      <= rollback_pos_from_rob;
        r_mem_req <= 1'b0;
        // A fetch still in flight must be swallowed before the new path starts.
        r_state   <= ((r_state != S_REQ) && !mem_valid_in) ? S_DROP : S_REQ;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
        case (r_state)
          S_REQ: begin
            if (!w_full) begin
              r_mem_req <= 1'b1;
              r_state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_valid_in) begin
              r_pc      <= w_next_pc;
              r_mem_req <= 1'b0;
              r_state   <= S_REQ;
            end
          end
          S_DROP: begin
            if (mem_valid_in) begin
              r_state <= S_REQ;
            end
          end
          default: begin
            r_mem_req <= 1'b0;
            r_state   <= S_REQ;
          end
        endcase
      end
    end
  end

  assign mem_req_out                  = r_mem_req;
  assign mem_addr_out                 = r_pc;
  assign idle_to_dispatcher           = w_idle;
  assign inst_to_dispatcher           = w_idle ? r_q_inst[r_head] : 32'h0;
  assign inst_pos_to_dispatcher       = w_idle ? r_q_pos[r_head]  : 32'h0;
  assign rollback_pos_to_dispatcher   = w_idle ? r_q_alt[r_head]  : 32'h0;
  assign jump_predicted_to_dispatcher = w_idle && r_q_pred[r_head];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// Randomized fetch-queue bench: reactive memory model plus a transaction-level
// reference of the PC, fetch-in-flight status and instruction queue.
module tb_fetch_queue_unit;
  localparam int          IQ_LOG = 2;
  localparam int          DEPTH  = 1 << IQ_LOG;
  localparam int          BLOG   = 6;
  localparam logic [31:0] RPC    = 32'h0;
  localparam logic [31:0] ADDI   = 32'h00000013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_valid_in = 1'b0;
  logic [31:0] mem_inst_in = 32'h0;
  logic        idle_to_dispatcher;
  logic [31:0] inst_to_dispatcher;
  logic [31:0] inst_pos_to_dispatcher;
  logic        jump_predicted_to_dispatcher;
  logic [31:0] rollback_pos_to_dispatcher;
  logic        stall_from_dispatcher = 1'b1;
  logic        rollback_flag_from_rob = 1'b0;
  logic [31:0] rollback_pos_from_rob = 32'h0;
  logic        bht_update_en_from_rob = 1'b0;
  logic [31:0] bht_update_pc_from_rob = 32'h0;
  logic        bht_taken_from_rob = 1'b0;

  always #5 clk_in = ~clk_in;

  fetch_queue_unit #(.IQ_DEPTH_LOG(IQ_LOG), .BHT_LOG(BLOG), .RESET_PC(RPC)) dut (
    .clk_in                       (clk_in),
    .rst_in                       (rst_in),
    .rdy_in                       (rdy_in),
    .mem_req_out                  (mem_req_out),
    .mem_addr_out                 (mem_addr_out),
    .mem_valid_in                 (mem_valid_in),
    .mem_inst_in                  (mem_inst_in),
    .idle_to_dispatcher           (idle_to_dispatcher),
    .inst_to_dispatcher           (inst_to_dispatcher),
    .inst_pos_to_dispatcher       (inst_pos_to_dispatcher),
    .jump_predicted_to_dispatcher (jump_predicted_to_dispatcher),
    .rollback_pos_to_dispatcher   (rollback_pos_to_dispatcher),
    .stall_from_dispatcher        (stall_from_dispatcher),
    .rollback_flag_from_rob       (rollback_flag_from_rob),
    .rollback_pos_from_rob        (rollback_pos_from_rob),
    .bht_update_en_from_rob       (bht_update_en_from_rob),
    .bht_update_pc_from_rob       (bht_update_pc_from_rob),
    .bht_taken_from_rob           (bht_taken_from_rob)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pos;
    logic [31:0] alt;
    logic        pred;
  } entry_t;

  // Reference state: what the fetch stage should hold, not how it is encoded.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_drop;
`ifdef FETCH_BHT_EN
  int          m_bht [1 << BLOG];
`endif

  logic [31:0] mem_img [logic [31:0]];
  bit          mo;
  int          mcnt;
  logic [31:0] maddr;
  int          mem_lat = 3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: w[6:0] = 7'b0010011;
      4, 5:       w[6:0] = 7'b1101111;
      6, 7, 8:    w[6:0] = 7'b1100011;
      default:    w[6:0] = 7'b1100111;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_img.exists(a)) mem_img[a] = rand_word();
    return mem_img[a];
  endfunction

  task automatic predict(input logic [31:0] pc, input logic [31:0] w,
                         output entry_t e, output logic [31:0] npc);
    logic [31:0] ij, ib;
    bit taken;
    ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    e.inst = w;
    e.pos  = pc;
    if (w[6:0] == 7'b1101111) begin
      e.pred = 1'b1; npc = pc + ij; e.alt = pc + 32'd4;
    end else if (w[6:0] == 7'b1100011) begin
      taken = 1'b0;
`ifdef FETCH_BHT_EN
      taken = (m_bht[pc[BLOG+1:2]] >= 2);
`endif
      e.pred = taken;
      npc    = taken ? pc + ib : pc + 32'd4;
      e.alt  = taken ? pc + 32'd4 : pc + ib;
    end else begin
      e.pred = 1'b0; npc = pc + 32'd4; e.alt = pc + 32'd4;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = RPC; m_busy = 0; m_drop = 0; mo = 0;
`ifdef FETCH_BHT_EN
    foreach (m_bht[i]) m_bht[i] = 1;
`endif
  endtask

  task automatic model_step(input bit stall, input bit rb, input logic [31:0] rbpos,
                            input bit valid, input logic [31:0] inst,
                            input bit upd_en, input logic [31:0] upd_pc, input bit upd_t,
                            input bit rdy);
    int sz;
    entry_t e;
    logic [31:0] npc;
    if (!rdy) return;
    sz = m_q.size();
    if (rb) begin
      m_q.delete();
      m_pc = rbpos;
      if (m_busy && !valid) m_drop = 1;
      else if (m_drop && valid) m_drop = 0;
      m_busy = 0;
    end else begin
      if (sz > 0 && !stall) void'(m_q.pop_front());
      if (m_busy && valid) begin
        predict(m_pc, inst, e, npc);
        m_q.push_back(e);
        m_pc = npc;
        m_busy = 0;
      end else if (m_drop) begin
        if (valid) m_drop = 0;
      end else if (!m_busy && sz < DEPTH) begin
        m_busy = 1;
      end
    end
`ifdef FETCH_BHT_EN
    if (upd_en) begin
      if (upd_t && m_bht[upd_pc[BLOG+1:2]] < 3) m_bht[upd_pc[BLOG+1:2]]++;
      else if (!upd_t && m_bht[upd_pc[BLOG+1:2]] > 0) m_bht[upd_pc[BLOG+1:2]]--;
    end
`else
    if (upd_en && upd_t && upd_pc == 32'hFFFF_FFFF) m_pc = m_pc;
`endif
  endtask

  task automatic compare_outputs();
    check_val("mem_req", mem_req_out, m_busy);
    check_val("mem_addr", mem_addr_out, m_pc);
    check_val("idle", idle_to_dispatcher, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check_val("head_inst", inst_to_dispatcher, m_q[0].inst);
      check_val("head_pos", inst_pos_to_dispatcher, m_q[0].pos);
      check_val("head_pred", jump_predicted_to_dispatcher, m_q[0].pred);
      check_val("head_alt", rollback_pos_to_dispatcher, m_q[0].alt);
    end
  endtask

  // One clock: check, let memory react, drive inputs, advance the reference.
  task automatic cycle(input bit stall, input bit rb, input logic [31:0] rbpos,
                       input bit upd_en, input logic [31:0] upd_pc, input bit upd_t,
                       input bit rdy);
    bit v;
    logic [31:0] w;
    compare_outputs();
    v = 0;
    w = $urandom;
    if (rdy) begin
      if (mo) begin
        mcnt--;
        if (mcnt == 0) begin v = 1; mo = 0; w = mem_word(maddr); end
      end else if (mem_req_out) begin
        mo = 1; maddr = mem_addr_out;
        mcnt = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end
    mem_valid_in = v; mem_inst_in = w;
    stall_from_dispatcher = stall;
    rollback_flag_from_rob = rb; rollback_pos_from_rob = rbpos;
    bht_update_en_from_rob = upd_en; bht_update_pc_from_rob = upd_pc;
    bht_taken_from_rob = upd_t; rdy_in = rdy;
    model_step(stall, rb, rbpos, v, w, upd_en, upd_pc, upd_t, rdy);
    @(negedge clk_in);
  endtask

  task automatic idle_cycles(input int n, input bit stall);
    for (int i = 0; i < n; i++) cycle(stall, 0, 32'h0, 0, 32'h0, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle_to_dispatcher && n < 40) begin idle_cycles(1, 1); n++; end
    check_val(tag, idle_to_dispatcher, 1);
  endtask

  initial begin
    int n;
    logic [31:0] upd_pc, rbpos;
    bit exp_pred;
    model_reset();
    for (int a = 0; a < 64; a += 4) mem_img[a] = ADDI;
    mem_img[32'h100] = ADDI;
    @(negedge clk_in);
    check_val("rst_req", mem_req_out, 0);
    check_val("rst_addr", mem_addr_out, RPC);
    check_val("rst_idle", idle_to_dispatcher, 0);
    check_val("rst_inst", inst_to_dispatcher, 0);
    check_val("rst_pos", inst_pos_to_dispatcher, 0);
    check_val("rst_alt", rollback_pos_to_dispatcher, 0);
    check_val("rst_pred", jump_predicted_to_dispatcher, 0);
    rst_in = 1'b1;

    // Fill under stall, then drain in order.
    idle_cycles(30, 1);
    check_val("full_no_req", mem_req_out, 0);
    for (int k = 0; k < DEPTH; k++) begin
      check_val("pop_order", inst_pos_to_dispatcher, 32'(4 * k));
      idle_cycles(1, 0);
    end

    // JAL +0x20 at 0x10.
    mem_img[32'h10] = 32'h0200006F;
    cycle(0, 1, 32'h10, 0, 32'h0, 0, 1);
    wait_idle("jal_timeout");
    check_val("jal_pos", inst_pos_to_dispatcher, 32'h10);
    check_val("jal_pred", jump_predicted_to_dispatcher, 1);
    check_val("jal_alt", rollback_pos_to_dispatcher, 32'h14);
    check_val("jal_next_addr", mem_addr_out, 32'h30);

    // BEQ -8 at 0x40, trained taken twice, then refetched.
    mem_img[32'h40] = 32'hFE000CE3;
    cycle(0, 1, 32'h40, 0, 32'h0, 0, 1);
    wait_idle("beq1_timeout");
    check_val("beq1_pred", jump_predicted_to_dispatcher, 0);
    check_val("beq1_alt", rollback_pos_to_dispatcher, 32'h38);
    check_val("beq1_next_addr", mem_addr_out, 32'h44);
    cycle(1, 0, 32'h0, 1, 32'h40, 1, 1);
    cycle(1, 0, 32'h0, 1, 32'h40, 1, 1);
    cycle(0, 1, 32'h40, 0, 32'h0, 0, 1);
    wait_idle("beq2_timeout");
`ifdef FETCH_BHT_EN
    exp_pred = 1;
`else
    exp_pred = 0;
`endif
    check_val("beq2_pred", jump_predicted_to_dispatcher, exp_pred);
    check_val("beq2_alt", rollback_pos_to_dispatcher, exp_pred ? 32'h44 : 32'h38);
    check_val("beq2_next_addr", mem_addr_out, exp_pred ? 32'h38 : 32'h44);

    // Rollback while a fetch is in flight; the late word must be dropped.
    mem_lat = 2;
    n = 0;
    while (!(mem_req_out && !mo) && n < 40) begin idle_cycles(1, 0); n++; end
    check_val("wait_req_timeout", mem_req_out, 1);
    cycle(0, 1, 32'h100, 0, 32'h0, 0, 1);
    check_val("drop_idle", idle_to_dispatcher, 0);
    check_val("drop_req", mem_req_out, 0);
    n = 0;
    while (!mem_req_out && n < 20) begin idle_cycles(1, 0); n++; end
    check_val("drop_refetch_addr", mem_addr_out, 32'h100);
    check_val("drop_queue_empty", idle_to_dispatcher, 0);

    // Rollback coincident with a response and a pop.
    mem_lat = 3;
    n = 0;
    while (!(m_q.size() > 0 && m_busy && mo && mcnt == 1) && n < 60) begin
      idle_cycles(1, 1); n++;
    end
    check_val("coinc_setup_timeout", idle_to_dispatcher, 1);
    cycle(0, 1, 32'h100, 0, 32'h0, 0, 1);
    check_val("coinc_idle", idle_to_dispatcher, 0);
    check_val("coinc_req", mem_req_out, 0);
    idle_cycles(1, 1);
    check_val("coinc_next_req", mem_req_out, 1);
    check_val("coinc_next_addr", mem_addr_out, 32'h100);

    // Asynchronous reset mid-fetch with three entries queued.
    n = 0;
    while (!(m_q.size() == 3 && m_busy) && n < 60) begin idle_cycles(1, 1); n++; end
    check_val("arst_setup_count", idle_to_dispatcher, 1);
    #2 rst_in = 1'b0;
    #1;
    check_val("arst_idle", idle_to_dispatcher, 0);
    check_val("arst_req", mem_req_out, 0);
    check_val("arst_addr", mem_addr_out, RPC);
    mem_valid_in = 1'b0; rollback_flag_from_rob = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    idle_cycles(1, 1);
    check_val("post_rst_req", mem_req_out, 1);
    check_val("post_rst_addr", mem_addr_out, RPC);

    // Randomized traffic.
    mem_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rbpos = 32'h40;
        1: rbpos = 32'h100;
        2: rbpos = 32'h200;
        default: rbpos = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      if ($urandom_range(0, 1)) upd_pc = 32'h40;
      else upd_pc = (m_q.size() > 0) ? m_q[0].pos : 32'($urandom);
      cycle($urandom_range(0, 1), $urandom_range(0, 99) < 3, rbpos,
            $urandom_range(0, 4) == 0, upd_pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
